blk_xfer_seq: RTL and testbench

BLK_XFER_SEQ -- requirements
Module: blk_xfer_seq

---
 rtl/blk_xfer_pkg.sv | 6 +
 rtl/prio_enc16.sv | 13 +
 rtl/blk_xfer_seq.sv | 132 +++++++++++++
 tb/tb_blk_xfer_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/blk_xfer_pkg.sv
// blk_xfer_pkg: shared state encoding, word size and address modes for the block transfer sequencer
package blk_xfer_pkg;
    localparam int WORD_BYTES = 4;
    typedef enum logic [2:0] {IDLE, SCAN, RDREG, MEM, WRREG, WB, DONE} state_e;
    typedef enum logic [1:0] {DEC_POST = 2'b00, DEC_PRE = 2'b01, INC_POST = 2'b10, INC_PRE = 2'b11} addr_mode_e;
endpackage

// File: rtl/prio_enc16.sv
// prio_enc16: index of the lowest set bit of a 16-bit vector plus a non-empty flag
module prio_enc16 (
    input  logic [15:0] vec,
    output logic [3:0]  idx,
    output logic        valid
);
    always_comb begin
        idx = '0;
        for (int i = 15; i >= 0; i--)
            if (vec[i]) idx = 4'(i);
    end
    assign valid = |vec;
endmodule

// File: rtl/blk_xfer_seq.sv
// blk_xfer_seq: LDM/STM block transfer sequencer between a register file and word-addressed memory
// Define BLK_XFER_WBACK_EN to build base-register writeback; otherwise wback is ignored.
module blk_xfer_seq
    import blk_xfer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic [15:0] reg_list,
    input  logic [3:0]  base_reg,
    input  logic [31:0] base_val,
    input  logic        up,
    input  logic        pre,
    input  logic        wback,
    output logic        busy,
    output logic        done,
    output logic [3:0]  rf_adrs,
    output logic        rf_wrten,
    output logic [31:0] rf_wrtd,
    input  logic [31:0] rf_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    state_e      state, state_n, last_n;
    logic [15:0] list_q;
    logic [3:0]  idx_q, enc_idx, wb_adrs;
    logic        enc_valid, load_q, first_q;
    logic [31:0] addr_q, wdata_q, ldata_q, span, first_addr, wb_data;

    function automatic logic [4:0] popcount(input logic [15:0] v);
        popcount = '0;
        for (int i = 0; i < 16; i++) popcount = popcount + 5'(v[i]);
    endfunction

    assign span = {25'd0, popcount(reg_list), 2'b00};

    always_comb begin
        first_addr = base_val;
        case (addr_mode_e'({up, pre}))
            INC_PRE:  first_addr = base_val + 32'(WORD_BYTES);
            INC_POST: first_addr = base_val;
            DEC_PRE:  first_addr = base_val - span;
            DEC_POST: first_addr = base_val - span + 32'(WORD_BYTES);
            default:  first_addr = base_val;
        endcase
    end

    prio_enc16 u_enc (.vec(list_q), .idx(enc_idx), .valid(enc_valid));

`ifdef BLK_XFER_WBACK_EN
    logic wb_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_q    <= 1'b0;
            wb_adrs <= '0;
            wb_data <= '0;
        end else if (state == IDLE && start) begin
            // a loaded base register takes precedence over the updated base
            wb_q    <= wback && !(is_load && reg_list[base_reg]);
            wb_adrs <= base_reg;
            wb_data <= up ? base_val + span : base_val - span;
        end
    end
    assign last_n = wb_q ? WB : DONE;
`else
    logic [4:0] wb_unused;
    assign wb_unused = {wback, base_reg};
    assign wb_adrs   = '0;
    assign wb_data   = '0;
    assign last_n    = DONE;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            list_q  <= '0;
            idx_q   <= '0;
            load_q  <= 1'b0;
            first_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ldata_q <= '0;
        end else begin
            state   <= state_n;
            first_q <= state != MEM;
            if (state == IDLE && start) begin
                list_q <= reg_list;
                load_q <= is_load;
                addr_q <= first_addr;
            end
            if (state == SCAN) begin
                idx_q  <= enc_idx;
                list_q <= list_q & ~(16'd1 << enc_idx);
            end
            // read data arrives in the first MEM cycle; hold it for the rest of the ack wait
            if (state == MEM && first_q) wdata_q <= rf_rdata;
            if (state == MEM && mem_ack) begin
                ldata_q <= mem_rdata;
                addr_q  <= addr_q + 32'(WORD_BYTES);
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (reg_list == '0) ? DONE : SCAN;
            SCAN:    state_n = load_q ? MEM : RDREG;
            RDREG:   state_n = MEM;
            MEM:     if (mem_ack) state_n = load_q ? WRREG : (enc_valid ? SCAN : last_n);
            WRREG:   state_n = enc_valid ? SCAN : last_n;
            WB:      state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign mem_req   = state == MEM;
    assign mem_we    = mem_req && !load_q;
    assign mem_addr  = mem_req ? addr_q : '0;
    assign mem_wdata = mem_we ? (first_q ? rf_rdata : wdata_q) : '0;
    assign rf_wrten  = state == WRREG || state == WB;
    assign rf_adrs   = (state == RDREG || state == WRREG) ? idx_q : (state == WB ? wb_adrs : '0);
    assign rf_wrtd   = state == WRREG ? ldata_q : (state == WB ? wb_data : '0);
endmodule

// File: tb/tb_blk_xfer_seq.sv
// tb_blk_xfer_seq: self-checking bench with register-file/memory models and a transaction scoreboard
module tb_blk_xfer_seq;
`ifdef BLK_XFER_WBACK_EN
    localparam bit WBEN = 1'b1;
`else
    localparam bit WBEN = 1'b0;
`endif
    typedef struct { logic [31:0] addr; logic we; logic [31:0] data; } mem_t;
    typedef struct { logic [3:0] adrs; logic [31:0] data; } rfw_t;

    logic clk = 0, rst = 0, start = 0, is_load = 0, up = 0, pre = 0, wback = 0;
    logic [15:0] reg_list = 0;
    logic [3:0]  base_reg = 0;
    logic [31:0] base_val = 0;
    logic busy, done, rf_wrten, mem_req, mem_we;
    logic [3:0]  rf_adrs;
    logic [31:0] rf_wrtd, mem_addr, mem_wdata;
    logic [31:0] rf_rdata = 0, mem_rdata = 0;
    logic mem_ack = 0;

    logic [31:0] regs [16];
    mem_t exp_mem[$], obs_mem[$];
    rfw_t exp_rf[$], obs_rf[$];
    int n_chk = 0, n_fail = 0, ack_wait = 0, req_cycles = 0;

    blk_xfer_seq dut (
        .clk(clk), .rst(rst), .start(start), .is_load(is_load), .reg_list(reg_list),
        .base_reg(base_reg), .base_val(base_val), .up(up), .pre(pre), .wback(wback),
        .busy(busy), .done(done), .rf_adrs(rf_adrs), .rf_wrten(rf_wrten), .rf_wrtd(rf_wrtd),
        .rf_rdata(rf_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] md(input logic [31:0] a);
        return (a * 32'd3) ^ 32'h5A5A0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // register file: synchronous read, write on the clock edge
    initial begin
        logic [3:0] a;
        logic w;
        logic [31:0] d;
        for (int i = 0; i < 16; i++) regs[i] = 32'hC0DE0000 | 32'(i);
        forever begin
            @(negedge clk);
            a = rf_adrs; w = rf_wrten; d = rf_wrtd;
            @(posedge clk);
            #1;
            if (w && rst) regs[a] = d;
            rf_rdata = regs[a];
        end
    end

    // memory: acks after ack_wait stall cycles, load data is a fixed function of the address
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                cnt++;
                mem_ack = cnt > ack_wait;
                mem_rdata = md(mem_addr);
            end else begin
                cnt = 0;
                mem_ack = 0;
            end
        end
    end

    // scoreboard: every cycle, compare DUT activity with the expected transaction queues
    initial begin
        logic held, pw;
        logic [31:0] pa, pd;
        mem_t em;
        rfw_t er;
        held = 0; pw = 0; pa = 0; pd = 0;
        forever begin
            @(negedge clk);
            if (!rst) held = 0;
            else begin
                chk("mem_rf_exclusive", {31'd0, mem_req & rf_wrten}, 0);
                if (mem_req || rf_wrten || done) chk("busy_when_active", {31'd0, busy}, 1);
                if (mem_req) begin
                    req_cycles++;
                    if (held) begin
                        chk("mem_addr_stable", mem_addr, pa);
                        chk("mem_we_stable", {31'd0, mem_we}, {31'd0, pw});
                        chk("mem_wdata_stable", mem_wdata, pd);
                    end
                    held = !mem_ack; pa = mem_addr; pw = mem_we; pd = mem_wdata;
                    if (mem_ack) begin
                        obs_mem.push_back(mem_t'{mem_addr, mem_we, mem_wdata});
                        chk("mem_expected", {31'd0, exp_mem.size() != 0}, 1);
                        if (exp_mem.size() != 0) begin
                            em = exp_mem.pop_front();
                            chk("mem_addr", mem_addr, em.addr);
                            chk("mem_we", {31'd0, mem_we}, {31'd0, em.we});
                            if (em.we) chk("mem_wdata", mem_wdata, em.data);
                        end
                    end
                end else held = 0;
                if (rf_wrten) begin
                    obs_rf.push_back(rfw_t'{rf_adrs, rf_wrtd});
                    chk("rf_expected", {31'd0, exp_rf.size() != 0}, 1);
                    if (exp_rf.size() != 0) begin
                        er = exp_rf.pop_front();
                        chk("rf_adrs", {28'd0, rf_adrs}, {28'd0, er.adrs});
                        chk("rf_wrtd", rf_wrtd, er.data);
                    end
                end
                if (done) chk("done_all_drained", 32'(exp_mem.size() + exp_rf.size()), 0);
            end
        end
    end

    // expected transactions and start-to-done latency, in edges from driving start to done being captured
    task automatic plan(input bit ld, input logic [15:0] list, input logic [3:0] breg, input logic [31:0] base,
                        input bit u, input bit p, input bit wb, input int w, output int lat);
        int n;
        logic [31:0] a, sp;
        bit wbx;
        n = $countones(list);
        sp = 32'(4 * n);
        case ({u, p})
            2'b11:   a = base + 4;
            2'b10:   a = base;
            2'b01:   a = base - sp;
            default: a = base - sp + 4;
        endcase
        for (int i = 0; i < 16; i++) if (list[i]) begin
            exp_mem.push_back(mem_t'{a, !ld, ld ? 32'd0 : regs[i]});
            if (ld) exp_rf.push_back(rfw_t'{4'(i), md(a)});
            a = a + 4;
        end
        wbx = WBEN && wb && n != 0 && !(ld && list[breg]);
        if (wbx) exp_rf.push_back(rfw_t'{breg, u ? base + sp : base - sp});
        lat = (n == 0) ? 2 : n * (3 + w) + int'(wbx) + 2;
    endtask

    task automatic xfer(input bit ld, input logic [15:0] list, input logic [3:0] breg, input logic [31:0] base,
                        input bit u, input bit p, input bit wb, input int w, input bit inj);
        int k, lat;
        plan(ld, list, breg, base, u, p, wb, w, lat);
        obs_mem.delete(); obs_rf.delete(); req_cycles = 0; ack_wait = w;
        @(posedge clk); #1;
        chk("idle_before_start", {31'd0, busy}, 0);
        is_load = ld; reg_list = list; base_reg = breg; base_val = base; up = u; pre = p; wback = wb; start = 1;
        @(posedge clk); #1;
        start = 0;
        k = 1;
        while (k < 600) begin
            @(negedge clk);
            if (done) break;
            @(posedge clk); #1;
            k++;
            if (inj && k == 4) begin
                start = 1; reg_list = 16'hFFFF; is_load = !ld; base_val = 32'hDEAD0000; up = !u;
            end else start = 0;
        end
        chk("done_seen", {31'd0, done}, 1);
        chk("done_latency", 32'(k + 1), 32'(lat));
        @(posedge clk); #1;
        chk("done_one_cycle", {31'd0, done}, 0);
        chk("idle_after_done", {31'd0, busy}, 0);
    endtask

    task automatic rst_outs();
        chk("rst_ctrl", {23'd0, busy, done, mem_req, mem_we, rf_wrten, rf_adrs}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rf_wrtd", rf_wrtd, 0);
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        rst_outs();
        @(posedge clk); #1;
        rst = 1;

        // STM R0,R1,R3 ascending from 0x100
        xfer(0, 16'h000B, 0, 32'h100, 1, 0, 0, 1, 0);
        chk("stm_count", 32'(obs_mem.size()), 3);
        chk("stm_no_rf_write", 32'(obs_rf.size()), 0);
        if (obs_mem.size() == 3) begin
            chk("stm_a0", obs_mem[0].addr, 32'h100);
            chk("stm_a1", obs_mem[1].addr, 32'h104);
            chk("stm_a2", obs_mem[2].addr, 32'h108);
            chk("stm_d0", obs_mem[0].data, 32'hC0DE0000);
            chk("stm_d2", obs_mem[2].data, 32'hC0DE0003);
        end

        // LDM R0,R15 pre-decrement from 0x200 with writeback to R2
        xfer(1, 16'h8001, 2, 32'h200, 0, 1, 1, 0, 0);
        chk("ldm_mem_count", 32'(obs_mem.size()), 2);
        chk("ldm_rf_count", 32'(obs_rf.size()), WBEN ? 3 : 2);
        if (obs_mem.size() == 2) begin
            chk("ldm_a0", obs_mem[0].addr, 32'h1F8);
            chk("ldm_a1", obs_mem[1].addr, 32'h1FC);
        end
        if (obs_rf.size() >= 2) begin
            chk("ldm_r0", {obs_rf[0].data[27:0], obs_rf[0].adrs}, {28'hA5A05E8, 4'd0});
            chk("ldm_r15", {obs_rf[1].data[27:0], obs_rf[1].adrs}, {28'hA5A05F4, 4'd15});
        end
        if (obs_rf.size() == 3) chk("ldm_wb_r2", {obs_rf[2].data[27:0], obs_rf[2].adrs}, {28'h00001F8, 4'd2});

        // empty list: straight to DONE
        xfer(0, 16'h0000, 0, 32'h100, 1, 1, 1, 0, 0);
        chk("empty_no_mem_req", 32'(req_cycles), 0);
        chk("empty_no_rf_write", 32'(obs_rf.size()), 0);

        // ack withheld 5 cycles with a start pulse injected mid-stall
        xfer(0, 16'h0030, 0, 32'h4000, 1, 1, 0, 5, 1);
        chk("stall_req_cycles", 32'(req_cycles), 12);
        if (obs_mem.size() == 2) begin
            chk("stall_a0", obs_mem[0].addr, 32'h4004);
            chk("stall_a1", obs_mem[1].addr, 32'h4008);
            chk("stall_d1", obs_mem[1].data, 32'hC0DE0005);
        end

        // loaded base register wins over writeback
        xfer(1, 16'h0002, 1, 32'h300, 1, 0, 1, 2, 0);
        chk("ldbase_rf_count", 32'(obs_rf.size()), 1);
        if (obs_rf.size() == 1) chk("ldbase_r1", {obs_rf[0].data[27:0], obs_rf[0].adrs}, {28'hA5A0900, 4'd1});

        // pre-decrement wrapping below zero
        xfer(0, 16'h0003, 5, 32'h0, 0, 1, 1, 0, 0);
        if (obs_mem.size() == 2) begin
            chk("wrap_a0", obs_mem[0].addr, 32'hFFFFFFF8);
            chk("wrap_a1", obs_mem[1].addr, 32'hFFFFFFFC);
        end

        // post-decrement
        xfer(1, 16'h0C00, 3, 32'h10, 0, 0, 1, 1, 0);
        if (obs_mem.size() == 2) chk("postdec_a0", obs_mem[0].addr, 32'hC);

        // asynchronous reset during MEM of the second register
        plan(0, 16'h0007, 0, 32'h800, 1, 0, 0, 4, lat);
        obs_mem.delete(); obs_rf.delete(); ack_wait = 4;
        @(posedge clk); #1;
        is_load = 0; reg_list = 16'h0007; base_reg = 0; base_val = 32'h800; up = 1; pre = 0; wback = 0; start = 1;
        @(posedge clk); #1;
        start = 0;
        for (int t = 0; t < 40 && !(mem_req && mem_addr == 32'h804); t++) @(negedge clk);
        chk("reach_second_mem", {31'd0, mem_req}, 1);
        #2 rst = 0;
        #1 rst_outs();
        chk("abort_one_mem", 32'(obs_mem.size()), 1);
        repeat (2) @(negedge clk);
        rst_outs();
        exp_mem.delete(); exp_rf.delete();
        @(negedge clk);
        rst = 1;
        xfer(1, 16'h00F0, 0, 32'h1000, 1, 1, 1, 0, 0);
        chk("after_reset_count", 32'(obs_mem.size()), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
